sprite_dma_swap: RTL
====================

// Module: sprite_dma_swap
// PURPOSE
// - Initiator for the single-port sync RAM (address/nwe/din/dout, write-cycle readback).
// - On start, sweeps len words of source RAM from base: each word is written with CLEAR_VAL while its
//   old contents are read back, then copied to a destination buffer port.
// - Sits between sprite RAM and the sprite line/object buffer; runs once per frame (vblank DMA).
// PARAMETERS
// - dataBits  16   word width of source RAM and destination port
// - addrBits  10   address width, source and destination
// - CLEAR_VAL 0    value written into every swept source word
// PORTS
// - clk       in   1         single clock, all logic on posedge
// - reset     in   1         asynchronous, active-high; all state and outputs to reset values
// - start     in   1         1-cycle request; sampled only in IDLE
// - base      in   addrBits  first source address; captured on accepted start
// - len       in   addrBits+1 word count, 0..2^addrBits; captured on accepted start
// - hold      in   1         pauses issuing new source accesses while high
// - abort     in   1         stops issuing; in-flight words still complete
// - src_addr  out  addrBits  source RAM address
// - src_nwe   out  1         source RAM write enable, active-low
// - src_din   out  dataBits  source RAM write data (always CLEAR_VAL)
// - src_dout  in   dataBits  source RAM readback, valid the cycle after an nwe-low edge
// - dst_addr  out  addrBits  destination offset (0..len-1)
// - dst_we    out  1         destination write strobe, active-high
// - dst_data  out  dataBits  destination write data
// - busy      out  1         high from cycle after accepted start until done
// - done      out  1         1-cycle pulse at end of transfer
// - aborted   out  1         set with done if abort cut the sweep short; cleared on next start
// BEHAVIOUR
// - Reset values: src_nwe=1, src_addr=0, src_din=CLEAR_VAL, dst_we=0, dst_addr=0, dst_data=0,
//   busy=0, done=0, aborted=0, FSM=IDLE. Reset mid-transfer discards all in-flight words.
// - FSM: IDLE -> RUN on start; RUN -> DRAIN when issue count reaches len or abort;
//   DRAIN -> FIN when pipeline empty; FIN asserts done for 1 cycle -> IDLE.
// - start in any state other than IDLE is ignored. len=0: IDLE->RUN->DRAIN->FIN,
//   no src or dst accesses, done 3 cycles after start.
// - Issue (RUN, hold=0, abort=0, k<len): src_nwe=0, src_addr=(base+k) mod 2^addrBits, k++.
//   src_nwe is high in every cycle with no issue (hold, IDLE, DRAIN, FIN).
// - Pipeline: issue in cycle n -> src_dout valid in n+1 -> registered to dst in n+2:
//   dst_we=1, dst_addr=k, dst_data=old word. Fixed latency 2; fully pipelined, 1 word/cycle.
// - hold gates issue only; words issued before hold rose still reach dst on schedule.
// - abort (RUN): no further issues, goes to DRAIN the same cycle, aborted=1 with done.
//   abort and the final issue in the same cycle: abort wins; that word is not issued.
// - Source addresses wrap modulo 2^addrBits; dst_addr never wraps (len <= 2^addrBits).
// - done never coincides with dst_we; last dst_we precedes done by exactly 1 cycle.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE/RUN/DRAIN/FIN), default CLEAR_VAL.
// - One sub-module: sprite_dma_pipe (2-stage valid/offset shift with dst output registers).
// - Issue counter, base/len capture and FSM stay in the top.
// TESTING
// - base=0x010,len=4, RAM 0x10..0x13=A,B,C,D -> dst_we on 4 consecutive cycles, offsets 0..3 = A..D;
//   RAM 0x10..0x13 read back CLEAR_VAL; done 1 cycle after last dst_we.
// - base=0x3FE,len=4 -> src_addr 0x3FE,0x3FF,0x000,0x001; dst offsets 0..3.
// - len=8, hold high on issue cycles 2-4 -> src_nwe high 3 cycles, dst order unchanged, 8 writes total.
// - len=16, abort on cycle of 6th issue -> exactly 5 dst writes, done with aborted=1.
// - start while busy -> ignored; base/len unchanged; len=0 -> no accesses, done 3 cycles after start.
// - reset pulse mid-RUN -> all outputs at reset values asynchronously; next start runs cleanly.

Source files
------------

// File: rtl/sprite_dma_swap_pkg.sv
// Shared types and defaults for the sprite RAM swap DMA.
package sprite_dma_swap_pkg;

  localparam int unsigned DEF_DATA_BITS = 16;
  localparam int unsigned DEF_ADDR_BITS = 10;
  localparam logic [DEF_DATA_BITS-1:0] DEF_CLEAR_VAL = '0;

  // Transfer sequencing: sweep source, let the readback pipe empty, pulse done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } dma_state_e;

endpackage

// File: rtl/sprite_dma_pipe.sv
// Two-stage readback pipe: issue -> source readback cycle -> destination write registers.
module sprite_dma_pipe
  import sprite_dma_swap_pkg::*;
#(
  parameter int unsigned dataBits = DEF_DATA_BITS,
  parameter int unsigned addrBits = DEF_ADDR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_i,
  input  logic [addrBits-1:0] offset_i,
  input  logic [dataBits-1:0] rdata_i,
  output logic                pending_o,
  output logic                dst_we_o,
  output logic [addrBits-1:0] dst_addr_o,
  output logic [dataBits-1:0] dst_data_o
);

  logic                s1_vld_q;
  logic [addrBits-1:0] s1_off_q;
  logic                dst_we_q;
  logic [addrBits-1:0] dst_addr_q;
  logic [dataBits-1:0] dst_data_q;

  // Stage 1 tracks the word whose old contents arrive on rdata_i this cycle; stage 2 presents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_off_q   <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      s1_vld_q <= issue_i;
      s1_off_q <= offset_i;
      dst_we_q <= s1_vld_q;
      if (s1_vld_q) begin
        dst_addr_q <= s1_off_q;
        dst_data_q <= rdata_i;
      end
    end
  end

  // Only stage 1 counts as pending so done lands exactly one cycle after the final write.
  assign pending_o  = s1_vld_q;
  assign dst_we_o   = dst_we_q;
  assign dst_addr_o = dst_addr_q;
  assign dst_data_o = dst_data_q;

endmodule

// File: rtl/sprite_dma_swap.sv
// Vblank DMA: clears a span of sprite RAM while copying its old contents to the line buffer.
module sprite_dma_swap
  import sprite_dma_swap_pkg::*;
#(
  parameter int unsigned           dataBits  = DEF_DATA_BITS,
  parameter int unsigned           addrBits  = DEF_ADDR_BITS,
  parameter logic [dataBits-1:0]   CLEAR_VAL = dataBits'(DEF_CLEAR_VAL)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrBits-1:0] base,
  input  logic [addrBits:0]   len,
  input  logic                hold,
  input  logic                abort,
  output logic [addrBits-1:0] src_addr,
  output logic                src_nwe,
  output logic [dataBits-1:0] src_din,
  input  logic [dataBits-1:0] src_dout,
  output logic [addrBits-1:0] dst_addr,
  output logic                dst_we,
  output logic [dataBits-1:0] dst_data,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int unsigned CntBits = addrBits + 1;

  dma_state_e          state_q, state_d;
  logic [addrBits-1:0] base_q, base_d;
  logic [CntBits-1:0]  len_q, len_d;
  logic [CntBits-1:0]  k_q, k_d;
  logic                cut_q, cut_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, done_q;
  logic                issue_c;
  logic                pending;

  // State and transfer-context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      cut_q     <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      k_q       <= k_d;
      cut_q     <= cut_d;
      aborted_q <= aborted_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FIN);
    end
  end

  // Next-state, issue decision and capture; abort beats a same-cycle issue.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    k_d       = k_q;
    cut_d     = cut_q;
    aborted_d = aborted_q;
    issue_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          base_d    = base;
          len_d     = len;
          k_d       = '0;
          cut_d     = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_RUN: begin
        issue_c = !hold && !abort && (k_q < len_q);
        if (issue_c) k_d = k_q + CntBits'(1);
        if (abort && (k_q < len_q)) cut_d = 1'b1;
        if (abort || (k_d == len_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pending) begin
          state_d   = ST_FIN;
          aborted_d = cut_q;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Source port is driven in the issue cycle itself so hold/abort act without delay.
  assign src_nwe  = ~issue_c;
  assign src_addr = issue_c ? (base_q + k_q[addrBits-1:0]) : '0;
  assign src_din  = CLEAR_VAL;

  sprite_dma_pipe #(
    .dataBits(dataBits),
    .addrBits(addrBits)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue_i   (issue_c),
    .offset_i  (k_q[addrBits-1:0]),
    .rdata_i   (src_dout),
    .pending_o (pending),
    .dst_we_o  (dst_we),
    .dst_addr_o(dst_addr),
    .dst_data_o(dst_data)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
